// File: rtl/pat_serializer.sv
// Pattern serializer: fetches 256-bit pattern words from a standard-mode FIFO and
// streams them LSB slice first to the imager mask driver, framed into sub-frames.
module pat_serializer #(
  parameter int WORDS_PER_SUBC = 640,
  parameter int LANE_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [31:0]       Num_Pat,
  input  logic [255:0]      pat_fifo_dout,
  input  logic              pat_fifo_empty,
  output logic              pat_fifo_rd_en,
  output logic [LANE_W-1:0] mask_data,
  output logic              mask_valid,
  input  logic              mask_ready,
  output logic              subc_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int                 SLICES     = 256 / LANE_W;
  localparam int                 SLICE_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);
  localparam logic [31:0]        WORDS      = 32'(WORDS_PER_SUBC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_NEXT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_num_sub;
  logic [31:0]        r_word_cnt;
  logic [31:0]        r_subc_cnt;
  logic [SLICE_W-1:0] r_slice_cnt;
  logic [255:0]       r_shift;

  logic        w_fire;
  logic        w_last_slice;
  logic        w_subc_end;
  logic        w_frame_end;
  logic [31:0] w_subc_inc;

  assign w_fire       = (r_state == S_SHIFT) && mask_ready;
  assign w_last_slice = w_fire && (r_slice_cnt == LAST_SLICE);
  assign w_subc_inc   = r_subc_cnt + 32'd1;
  assign w_subc_end   = (r_state == S_NEXT) && !(r_word_cnt < WORDS);
  // The frame ends when the sub-frame count after this increment reaches num_sub.
  assign w_frame_end  = w_subc_end && !(w_subc_inc < r_num_sub);

  // Outputs are gated by rst so they read zero for the whole time reset is held,
  // including the cycle before the first reset edge lands in the registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_next         = r_state;
    pat_fifo_rd_en = 1'b0;
    mask_valid     = 1'b0;
    mask_data      = '0;
    subc_done      = 1'b0;
    frame_done     = 1'b0;
    busy           = 1'b0;

    case (r_state)
      S_IDLE:  if (enable) w_next = S_FETCH;
      S_FETCH: if (!pat_fifo_empty) w_next = S_WAIT;
      S_WAIT:  w_next = S_SHIFT;
      S_SHIFT: if (w_last_slice) w_next = S_NEXT;
      S_NEXT:  w_next = w_frame_end ? S_IDLE : S_FETCH;
      default: w_next = S_IDLE;
    endcase

    if (rst) begin
      pat_fifo_rd_en = (r_state == S_FETCH) && !pat_fifo_empty;
      mask_valid     = (r_state == S_SHIFT);
      mask_data      = r_shift[LANE_W-1:0];
      subc_done      = w_subc_end;
      frame_done     = w_frame_end;
      busy           = (r_state != S_IDLE);
    end
  end

  // NOTE: reset is synchronous and active-low, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_num_sub   <= 32'd0;
      r_word_cnt  <= 32'd0;
      r_subc_cnt  <= 32'd0;
      r_slice_cnt <= '0;
      r_shift     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_num_sub  <= (Num_Pat == 32'd0) ? 32'd1 : Num_Pat;
            r_word_cnt <= 32'd0;
            r_subc_cnt <= 32'd0;
          end
        end
        S_WAIT: begin
          r_shift     <= pat_fifo_dout;
          r_slice_cnt <= '0;
        end
        S_SHIFT: begin
          if (w_fire) begin
            r_shift     <= r_shift >> LANE_W;
            r_slice_cnt <= r_slice_cnt + 1'b1;
            if (w_last_slice) r_word_cnt <= r_word_cnt + 32'd1;
          end
        end
        S_NEXT: begin
          if (w_subc_end) begin
            r_word_cnt <= 32'd0;
            r_subc_cnt <= w_subc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pat_serializer.sv
// Self-checking bench for pat_serializer: FIFO model plus a slice scoreboard that is
// filled when words are written into the FIFO model and drained on each handshake.
module tb_pat_serializer;

  localparam int WPS    = 2;
  localparam int LANE_W = 32;
  localparam int SLICES = 256 / LANE_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [31:0]       Num_Pat = 32'd0;
  logic [255:0]      pat_fifo_dout = '0;
  logic              pat_fifo_empty;
  logic              pat_fifo_rd_en;
  logic [LANE_W-1:0] mask_data;
  logic              mask_valid;
  logic              mask_ready = 1'b1;
  logic              subc_done;
  logic              frame_done;
  logic              busy;

  pat_serializer #(.WORDS_PER_SUBC(WPS), .LANE_W(LANE_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .Num_Pat       (Num_Pat),
    .pat_fifo_dout (pat_fifo_dout),
    .pat_fifo_empty(pat_fifo_empty),
    .pat_fifo_rd_en(pat_fifo_rd_en),
    .mask_data     (mask_data),
    .mask_valid    (mask_valid),
    .mask_ready    (mask_ready),
    .subc_done     (subc_done),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Standard-mode FIFO model: data appears the cycle after the read strobe.
  logic [255:0] fifo_mem [64];
  int           push_cnt = 0;
  int           pop_cnt  = 0;
  logic         force_empty = 1'b0;

  assign pat_fifo_empty = force_empty || (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (pat_fifo_rd_en) begin
      pat_fifo_dout <= fifo_mem[pop_cnt % 64];
      pop_cnt       <= pop_cnt + 1;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  int          hs_cnt, sc_cnt, fr_cnt;
  logic        prev_rd = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;
  logic        obs_rd, obs_valid, obs_busy, obs_subc, obs_frame;
  logic [36:0] obs_all;

  function automatic logic [255:0] mk_word(input int k);
    logic [255:0] w;
    for (int b = 0; b < 32; b++) w[b*8 +: 8] = 8'(k * 32 + b + 1);
    return w;
  endfunction

  task automatic push_word(input int k);
    logic [255:0] w;
    w = mk_word(k);
    fifo_mem[push_cnt % 64] = w;
    push_cnt++;
    for (int s = 0; s < SLICES; s++) exp_q.push_back(w[s*LANE_W +: LANE_W]);
  endtask

  // One clock: observe at the falling edge, then return just after the rising edge.
  task automatic tick();
    logic [31:0] exp;
    @(negedge clk);
    obs_rd    = pat_fifo_rd_en;
    obs_valid = mask_valid;
    obs_busy  = busy;
    obs_subc  = subc_done;
    obs_frame = frame_done;
    obs_all   = {pat_fifo_rd_en, mask_valid, subc_done, frame_done, busy, mask_data};
    if (rst && mask_valid && mask_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL slice_extra: got %h, expected no slice", mask_data);
      end else begin
        exp = exp_q.pop_front();
        if (mask_data !== exp) begin
          errors++;
          $display("FAIL slice_%0d: got %h, expected %h", hs_cnt, mask_data, exp);
        end
      end
      hs_cnt++;
    end
    if (prev_hold && mask_valid) begin
      checks++;
      if (mask_data !== prev_data) begin
        errors++;
        $display("FAIL hold_stable: got %h, expected %h", mask_data, prev_data);
      end
    end
    prev_hold = rst && mask_valid && !mask_ready;
    prev_data = mask_data;
    if (pat_fifo_rd_en) begin
      checks++;
      if (pat_fifo_empty || prev_rd) begin
        errors++;
        $display("FAIL rd_en_rule: got empty=%b prev_rd=%b, expected 0/0", pat_fifo_empty, prev_rd);
      end
    end
    prev_rd = pat_fifo_rd_en;
    if (frame_done) begin
      checks++;
      if (subc_done !== 1'b1) begin
        errors++;
        $display("FAIL frame_with_subc: got subc_done=%b, expected 1", subc_done);
      end
    end
    if (subc_done) sc_cnt++;
    if (frame_done) fr_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] np);
    hs_cnt  = 0;
    sc_cnt  = 0;
    fr_cnt  = 0;
    Num_Pat = np;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (!obs_busy) break;
    end
    checks++;
    if (obs_busy) begin
      errors++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_all !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h, expected 0", obs_all);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b, expected 0", obs_busy);
    end
  endtask

  task automatic test_basic();
    push_word(0);
    push_word(1);
    start_frame(32'd1);
    wait_idle(100, "basic");
    checks++;
    if (hs_cnt != 16 || exp_q.size() != 0 || sc_cnt != 1 || fr_cnt != 1 || pop_cnt != push_cnt) begin
      errors++;
      $display("FAIL basic_frame: got slices=%0d left=%0d subc=%0d frame=%0d, expected 16/0/1/1",
               hs_cnt, exp_q.size(), sc_cnt, fr_cnt);
    end
  endtask

  task automatic test_num_pat_zero();
    push_word(2);
    push_word(3);
    start_frame(32'd0);
    wait_idle(100, "np0");
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (hs_cnt != 16 || exp_q.size() != 0 || sc_cnt != 1 || fr_cnt != 1 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL np0_frame: got slices=%0d subc=%0d frame=%0d busy=%b, expected 16/1/1/0",
               hs_cnt, sc_cnt, fr_cnt, obs_busy);
    end
  endtask

  task automatic test_fifo_empty();
    force_empty = 1'b1;
    push_word(4);
    push_word(5);
    start_frame(32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (obs_rd !== 1'b0 || obs_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_stall_%0d: got rd_en=%b valid=%b, expected 0/0", i, obs_rd, obs_valid);
      end
    end
    force_empty = 1'b0;
    tick();
    checks++;
    if (obs_rd !== 1'b1) begin
      errors++;
      $display("FAIL empty_resume_rd: got %b, expected 1", obs_rd);
    end
    tick();
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_n1: got valid=%b, expected 0", obs_valid);
    end
    tick();
    checks++;
    if (obs_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_n2: got valid=%b, expected 1", obs_valid);
    end
    wait_idle(100, "empty");
    checks++;
    if (hs_cnt != 16 || exp_q.size() != 0 || fr_cnt != 1) begin
      errors++;
      $display("FAIL empty_frame: got slices=%0d frame=%0d, expected 16/1", hs_cnt, fr_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int         n;
    pat = 4'b1001;
    n   = 0;
    push_word(6);
    push_word(7);
    start_frame(32'd1);
    while (n < 200) begin
      mask_ready = pat[n % 4];
      tick();
      n++;
      if (!obs_busy) break;
    end
    mask_ready = 1'b1;
    checks++;
    if (obs_busy || hs_cnt != 16 || exp_q.size() != 0 || sc_cnt != 1 || fr_cnt != 1) begin
      errors++;
      $display("FAIL backpressure_frame: got busy=%b slices=%0d left=%0d, expected 0/16/0",
               obs_busy, hs_cnt, exp_q.size());
    end
  endtask

  task automatic test_multi_subframe();
    bit seen;
    seen = 1'b0;
    for (int k = 8; k < 14; k++) push_word(k);
    start_frame(32'd3);
    for (int n = 0; n < 300 && !seen; n++) begin
      tick();
      if (obs_frame) begin
        seen = 1'b1;
        checks++;
        if (sc_cnt != 3 || obs_subc !== 1'b1) begin
          errors++;
          $display("FAIL multi_frame_on_third: got subc=%0d, expected 3", sc_cnt);
        end
        tick();
        checks++;
        if (obs_busy !== 1'b0) begin
          errors++;
          $display("FAIL multi_busy_fall: got %b, expected 0", obs_busy);
        end
      end
    end
    checks++;
    if (!seen || fr_cnt != 1 || hs_cnt != 48 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL multi_frame: got seen=%0d frame=%0d slices=%0d, expected 1/1/48",
               seen, fr_cnt, hs_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    push_word(14);
    push_word(15);
    start_frame(32'd1);
    for (int n = 0; n < 100 && hs_cnt < SLICES + 4; n++) tick();
    checks++;
    if (hs_cnt != SLICES + 4) begin
      errors++;
      $display("FAIL midrst_reach: got %0d slices, expected %0d", hs_cnt, SLICES + 4);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_all !== '0) begin
        errors++;
        $display("FAIL midrst_outputs_%0d: got %h, expected 0", i, obs_all);
      end
    end
    checks++;
    if (sc_cnt != 0 || fr_cnt != 0) begin
      errors++;
      $display("FAIL midrst_no_pulse: got subc=%0d frame=%0d, expected 0/0", sc_cnt, fr_cnt);
    end
    exp_q.delete();
    rst = 1'b1;
    push_word(20);
    push_word(21);
    start_frame(32'd1);
    wait_idle(100, "restart");
    checks++;
    if (hs_cnt != 16 || exp_q.size() != 0 || sc_cnt != 1 || fr_cnt != 1 || pop_cnt != push_cnt) begin
      errors++;
      $display("FAIL restart_frame: got slices=%0d left=%0d subc=%0d frame=%0d, expected 16/0/1/1",
               hs_cnt, exp_q.size(), sc_cnt, fr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_num_pat_zero();
    test_fifo_empty();
    test_backpressure();
    test_multi_subframe();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
